// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states and
// the wait-state counter width helper.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Counter runs 0..wait_cyc-1, so it never needs more than clog2(wait_cyc) bits.
   function automatic int unsigned cnt_width(input int unsigned wait_cyc);
      return (wait_cyc < 2) ? 1 : $clog2(wait_cyc);
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the data-memory controller.
// PInj exists only when DMEM_PARITY_EN is defined.
interface dmem_ctrl_if;
   logic [31:0] Addr;
   logic        Read;
   logic        Write;
   logic [1:0]  Size;
   logic [31:0] WData;
   logic [31:0] RData;
   logic        Ack;
   logic        Busy;
   logic        Err;
`ifdef DMEM_PARITY_EN
   logic        PInj;

   modport master (output Addr, Read, Write, Size, WData, PInj,
                   input  RData, Ack, Busy, Err);
   modport slave  (input  Addr, Read, Write, Size, WData, PInj,
                   output RData, Ack, Busy, Err);
`else
   modport master (output Addr, Read, Write, Size, WData,
                   input  RData, Ack, Busy, Err);
   modport slave  (input  Addr, Read, Write, Size, WData,
                   output RData, Ack, Busy, Err);
`endif
endinterface

// File: rtl/dmem_bytelane.sv
// Combinational lane steering: byte-enable mask, write-data replication and
// read-data right-alignment with zero extension.
module dmem_bytelane
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  size_e       size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  mask_o,
   output logic [31:0] wrep_o,
   output logic [31:0] rdata_o
);
   always_comb begin
      mask_o  = '0;
      wrep_o  = '0;
      rdata_o = '0;
      case (size_i)
         SZ_BYTE: begin
            mask_o  = 4'b0001 << addr_lo_i;
            wrep_o  = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, rword_i[{addr_lo_i, 3'b000} +: 8]};
         end
         SZ_HALF: begin
            mask_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wrep_o  = {2{wdata_i[15:0]}};
            rdata_o = {16'h0, rword_i[{addr_lo_i[1], 4'b0000} +: 16]};
         end
         SZ_WORD: begin
            mask_o  = 4'b1111;
            wrep_o  = wdata_i;
            rdata_o = rword_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with wait states, fault detection and one-cycle Ack.
// Optional per-byte even parity with error injection under DMEM_PARITY_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned WAIT_CYC  = 1
) (
   input logic        C,
   input logic        R,
   dmem_ctrl_if.slave bus
);
   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   CW       = cnt_width(WAIT_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [AW+1:0] addr_q;
   size_e         size_q;
   logic [31:0]   wdata_q;
   logic          rd_q, wr_q, fault_q;
   logic          ack_q, busy_q, err_q;
   logic [31:0]   rdata_q;
   logic [31:0]   mem_q [DEPTH];

   logic          req_fault;
   logic [AW+1:0] cur_addr;
   size_e         cur_size;
   logic [31:0]   cur_wdata;
   logic          cur_rd, cur_fault;
   logic [AW-1:0] cur_idx;
   logic [31:0]   rword, lane_wdata, lane_rdata, resp_rdata;
   logic [3:0]    lane_mask;
   logic          par_err, resp_err;

   always_comb begin
      req_fault = (bus.Addr[31:AW+2] != BASE_ADDR[31:AW+2]);
      case (size_e'(bus.Size))
         SZ_HALF: req_fault = req_fault | bus.Addr[0];
         SZ_WORD: req_fault = req_fault | (|bus.Addr[1:0]);
         SZ_RSVD: req_fault = 1'b1;
         default: ;
      endcase
      if (bus.Read && bus.Write) req_fault = 1'b1;
   end

   // In IDLE the live request feeds the datapath so WAIT_CYC=0 can respond
   // straight from accept; otherwise the latched request is used.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_addr  = bus.Addr[AW+1:0];
         cur_size  = size_e'(bus.Size);
         cur_wdata = bus.WData;
         cur_rd    = bus.Read;
         cur_fault = req_fault;
      end else begin
         cur_addr  = addr_q;
         cur_size  = size_q;
         cur_wdata = wdata_q;
         cur_rd    = rd_q;
         cur_fault = fault_q;
      end
   end

   assign cur_idx = cur_addr[AW+1:2];
   assign rword   = mem_q[cur_idx];

   dmem_bytelane u_lane (
      .addr_lo_i (cur_addr[1:0]),
      .size_i    (cur_size),
      .wdata_i   (cur_wdata),
      .rword_i   (rword),
      .mask_o    (lane_mask),
      .wrep_o    (lane_wdata),
      .rdata_o   (lane_rdata)
   );

`ifdef DMEM_PARITY_EN
   logic [3:0] par_q [DEPTH];
   logic       pinj_q;

   always_comb begin
      par_err = 1'b0;
      for (int unsigned i = 0; i < 4; i++)
         if (lane_mask[i] && (par_q[cur_idx][i] != ^rword[8*i +: 8])) par_err = 1'b1;
   end
`else
   assign par_err = 1'b0;
`endif

   assign resp_rdata = (cur_fault || !cur_rd) ? '0 : lane_rdata;
   assign resp_err   = cur_fault || (cur_rd && par_err);

   always_ff @(posedge C) begin
      if (R) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
`ifdef DMEM_PARITY_EN
         pinj_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (bus.Read || bus.Write) begin
               addr_q  <= bus.Addr[AW+1:0];
               size_q  <= size_e'(bus.Size);
               wdata_q <= bus.WData;
               rd_q    <= bus.Read;
               wr_q    <= bus.Write;
               fault_q <= req_fault;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
`ifdef DMEM_PARITY_EN
               pinj_q  <= bus.PInj;
`endif
               if (WAIT_CYC == 0) begin
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= resp_err;
                  rdata_q <= resp_rdata;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: if (cnt_q == CNT_LAST) begin
               state_q <= ST_RESP;
               ack_q   <= 1'b1;
               err_q   <= resp_err;
               rdata_q <= resp_rdata;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               cnt_q   <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Storage is never reset; a reset in RESP suppresses the commit.
   always_ff @(posedge C) begin
      if (!R && state_q == ST_RESP && wr_q && !fault_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
               mem_q[cur_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
               par_q[cur_idx][i] <= (^lane_wdata[8*i +: 8]) ^ pinj_q;
`endif
            end
         end
      end
   end

   assign bus.RData = rdata_q;
   assign bus.Ack   = ack_q;
   assign bus.Busy  = busy_q;
   assign bus.Err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-addressed reference model, directed
// scenarios and randomized traffic; DMEM_PARITY_EN adds parity-injection tests.
module tb_dmem_ctrl;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned WAIT_CYC = 1;
   localparam logic [31:0] BASE     = 32'h0000_0000;
`ifdef DMEM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_ctrl_if bus ();

   dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYC(WAIT_CYC)) dut (
      .C   (clk),
      .R   (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned cyc;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;
   logic [7:0]  mdl [4*DEPTH];
   bit          bad [4*DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: memory as a flat byte array, faults from the access rules.
   function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [1:0] sz, input logic [31:0] wd, input bit pinj,
                                 output logic [31:0] rdata, output logic err);
      logic [31:0] off;
      int unsigned n;
      bit          flt;
      off = a - BASE;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      flt = (off >= 4*DEPTH) || (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
            (sz == 2'd2 && a % 4 != 0) || (rd && wr);
      rdata = '0;
      err   = flt;
      if (!flt && wr)
         for (int unsigned i = 0; i < n; i++) begin
            mdl[off+i] = wd[8*i +: 8];
            bad[off+i] = pinj && PAR;
         end
      if (!flt && rd)
         for (int unsigned i = 0; i < n; i++) begin
            rdata = rdata | (32'(mdl[off+i]) << (8*i));
            if (bad[off+i]) err = 1'b1;
         end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (bus.Ack === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got Ack=1 at cycle %0d expected none", cyc);
            end else begin
               e = sbq.pop_front();
               chk({e.tag, "_rdata"}, bus.RData, e.rdata);
               chk({e.tag, "_err"}, 32'(bus.Err), 32'(e.err));
               chk({e.tag, "_ackcyc"}, 32'(cyc), 32'(e.cyc));
            end
         end else begin
            chk("rdata_without_ack", bus.RData, 32'h0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.Busy !== 1'b0) begin
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got Busy=%b expected 0 within 50 cycles", bus.Busy);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input bit pinj, input string tag, input bit resp);
      logic [31:0] r;
      logic        e;
      bus.Read  = rd;
      bus.Write = wr;
      bus.Addr  = a;
      bus.Size  = sz;
      bus.WData = wd;
`ifdef DMEM_PARITY_EN
      bus.PInj  = pinj;
`endif
      @(posedge clk);
      #1;
      if (resp) begin
         model(rd, wr, a, sz, wd, pinj, r, e);
         sbq.push_back('{r, e, cyc + WAIT_CYC, tag});
      end
      chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
   endtask

   task automatic release_bus();
      bus.Read  = 1'b0;
      bus.Write = 1'b0;
`ifdef DMEM_PARITY_EN
      bus.PInj  = 1'b0;
`endif
   endtask

   task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input bit pinj, input string tag);
      wait_idle();
      issue(rd, wr, a, sz, wd, pinj, tag, 1'b1);
      release_bus();
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      bus.Addr  = '0;
      bus.Size  = 2'b10;
      bus.WData = '0;
      release_bus();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ack", 32'(bus.Ack), 32'd0);
      chk("reset_busy", 32'(bus.Busy), 32'd0);
      chk("reset_err", 32'(bus.Err), 32'd0);
      chk("reset_rdata", bus.RData, 32'h0);
      rst = 1'b0;

      for (int unsigned w = 0; w < DEPTH; w++)
         req(1'b0, 1'b1, BASE + 4*w, 2'b10, $urandom, 1'b0, "init");

      req(1'b0, 1'b1, 32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0, "w_word10");
      req(1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, "r_word10");
      req(1'b0, 1'b1, 32'h11, 2'b00, 32'h0000_005A, 1'b0, "w_byte11");
      req(1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, "r_word10_merged");
      req(1'b1, 1'b0, 32'h12, 2'b01, 32'h0, 1'b0, "r_half12");

      req(1'b1, 1'b0, 32'h13, 2'b01, 32'h0, 1'b0, "f_half13");
      req(1'b1, 1'b0, 32'h80, 2'b10, 32'h0, 1'b0, "f_oor80");
      req(1'b1, 1'b1, 32'h10, 2'b10, 32'h1111_2222, 1'b0, "f_rdwr");
      req(1'b0, 1'b1, 32'h16, 2'b10, 32'h3333_4444, 1'b0, "f_wmisalign");
      req(1'b0, 1'b1, 32'h10, 2'b11, 32'h5555_6666, 1'b0, "f_rsvd");
      req(1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, "r_word10_kept");

      // Second read held through Busy must be taken only after Busy falls.
      wait_idle();
      issue(1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0, "r_first", 1'b1);
      bus.Addr = 32'h14;
      wait_idle();
      issue(1'b1, 1'b0, 32'h14, 2'b10, 32'h0, 1'b0, "r_held", 1'b1);
      release_bus();

      // Reset while waiting aborts the write.
      wait_idle();
      issue(1'b0, 1'b1, 32'h20, 2'b10, 32'h1234_5678, 1'b0, "w_abort", 1'b0);
      release_bus();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 32'(bus.Busy), 32'd0);
      chk("abort_ack", 32'(bus.Ack), 32'd0);
      req(1'b1, 1'b0, 32'h20, 2'b10, 32'h0, 1'b0, "r_word20_kept");

`ifdef DMEM_PARITY_EN
      req(1'b0, 1'b1, 32'h30, 2'b10, 32'hA5C3_0F71, 1'b1, "w_pinj");
      req(1'b1, 1'b0, 32'h30, 2'b10, 32'h0, 1'b0, "r_pinj");
      req(1'b1, 1'b0, 32'h31, 2'b00, 32'h0, 1'b0, "r_pinj_byte");
      req(1'b0, 1'b1, 32'h30, 2'b10, 32'h0BAD_F00D, 1'b0, "w_clean");
      req(1'b1, 1'b0, 32'h30, 2'b10, 32'h0, 1'b0, "r_clean");
`endif

      for (int k = 0; k < 200; k++) begin
         int unsigned kind;
         logic [31:0] a;
         kind = $urandom_range(0, 9);
         a    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 15));
         req(kind < 5 || kind == 9, kind >= 5, a, 2'($urandom_range(0, 3)), $urandom,
             PAR && ($urandom_range(0, 4) == 0), "rand");
      end

      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d responses outstanding expected 0", sbq.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
